gemm_tile_sequencer: RTL and testbench

- Parametrised tile-loop controller for the GEMM accelerator. It walks the runtime-sized (M_size × K_size × N_size) problem in M×K×N hardware tiles.
- Drives the A/B SRAM read addresses, the MAC accumulate controls and the C SRAM write address/enable.
- Successor to the fixed-order controller. Adds selectable loop order (weight-reuse or input-reuse), backpressure stall, and size-error detection.
- Sits between gemm_accelerator_top's start/done interface and the MAC array.

---
 rtl/gemm_pkg.sv | 19 +
 rtl/gemm_wrap_counter.sv | 25 ++
 rtl/gemm_tile_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_gemm_tile_sequencer.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// Shared types for the GEMM tile sequencer.
// Sequencer states, loop-order encoding and pipeline depth.
package gemm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } seq_state_e;

    typedef enum logic {
        MODE_N_INNER = 1'b0,
        MODE_M_INNER = 1'b1
    } loop_mode_e;

    localparam int PIPE_DEPTH = 2;

endpackage

// File: rtl/gemm_wrap_counter.sv
// Wrapping tile counter: counts 0..max on en, flags the last value.
// Cleared by reset or by clr (new problem accepted).
module gemm_wrap_counter #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] max,
    output logic [W-1:0] count,
    output logic         last
);

    assign last = (count == max);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/gemm_tile_sequencer.sv
// GEMM tile-loop controller with selectable loop order and stall.
// Define GEMM_SEQ_PERF_EN to add cycle/stall performance counters.
module gemm_tile_sequencer
    import gemm_pkg::*;
#(
    parameter int M          = 2,
    parameter int K          = 32,
    parameter int N          = 1,
    parameter int SizeWidth  = 7,
    parameter int AddrWidth  = 6,
    parameter int AddrWidthC = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  mode_i,
    input  logic [SizeWidth-1:0]  M_size_i,
    input  logic [SizeWidth-1:0]  K_size_i,
    input  logic [SizeWidth-1:0]  N_size_i,
    input  logic                  stall_i,
    output logic [AddrWidth-1:0]  sram_a_addr_o,
    output logic [AddrWidth-1:0]  sram_b_addr_o,
    output logic                  mac_valid_o,
    output logic                  acc_clear_o,
    output logic                  sram_c_we_o,
    output logic [AddrWidthC-1:0] sram_c_addr_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
`ifdef GEMM_SEQ_PERF_EN
    ,
    output logic [31:0]           perf_cycles_o,
    output logic [31:0]           perf_stalls_o
`endif
);

    localparam int MSh = $clog2(M);
    localparam int KSh = $clog2(K);
    localparam int NSh = $clog2(N);
    localparam int PW  = 2 * SizeWidth;

    seq_state_e state, state_n;
    loop_mode_e mode_q;
    logic       err_q;

    logic [SizeWidth-1:0] kt_n, nt_n;
    logic [SizeWidth-1:0] mt_max, kt_max, nt_max;
    logic [SizeWidth-1:0] mt, kt, nt;
    logic mt_last, kt_last, nt_last;
    logic legal, accept, issue;
    logic mt_en, nt_en;

    logic                  v1, clr1, lk1, we2;
    logic [AddrWidthC-1:0] caddr1, caddr2;
    logic [1:0]            drain_q;
    logic [PW-1:0]         a_full, b_full, c_full;

    assign legal = (M_size_i != '0) && ((M_size_i & SizeWidth'(M - 1)) == '0)
                && (K_size_i != '0) && ((K_size_i & SizeWidth'(K - 1)) == '0)
                && (N_size_i != '0) && ((N_size_i & SizeWidth'(N - 1)) == '0);

    assign accept = (state == IDLE) && start_i && !stall_i;
    assign issue  = (state == RUN) && !stall_i;

    // Inner counter steps on every k wrap; outer only when inner wraps too.
    assign mt_en = issue && kt_last && (mode_q == MODE_M_INNER || nt_last);
    assign nt_en = issue && kt_last && (mode_q == MODE_N_INNER || mt_last);

    gemm_wrap_counter #(.W(SizeWidth)) u_kt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (accept),
        .en    (issue),
        .max   (kt_max),
        .count (kt),
        .last  (kt_last)
    );

    gemm_wrap_counter #(.W(SizeWidth)) u_mt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (accept),
        .en    (mt_en),
        .max   (mt_max),
        .count (mt),
        .last  (mt_last)
    );

    gemm_wrap_counter #(.W(SizeWidth)) u_nt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (accept),
        .en    (nt_en),
        .max   (nt_max),
        .count (nt),
        .last  (nt_last)
    );

    assign a_full = PW'(mt) * PW'(kt_n) + PW'(kt);
    assign b_full = PW'(kt) * PW'(nt_n) + PW'(nt);
    assign c_full = PW'(mt) * PW'(nt_n) + PW'(nt);

    assign sram_a_addr_o = a_full[AddrWidth-1:0];
    assign sram_b_addr_o = b_full[AddrWidth-1:0];
    assign sram_c_addr_o = caddr2;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start_i && !stall_i) begin
                    state_n = legal ? RUN : DONE;
                end
            end
            RUN: begin
                if (issue && kt_last && mt_last && nt_last) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (!stall_i && drain_q == 2'(PIPE_DEPTH - 1)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (!stall_i) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state == RUN) || (state == DRAIN);
        done_o      = (state == DONE) && !stall_i;
        err_o       = (state == DONE) && !stall_i && err_q;
        mac_valid_o = v1 && !stall_i;
        acc_clear_o = v1 && !stall_i && clr1;
        sram_c_we_o = we2 && !stall_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q  <= MODE_N_INNER;
            err_q   <= 1'b0;
            kt_n    <= '0;
            nt_n    <= '0;
            mt_max  <= '0;
            kt_max  <= '0;
            nt_max  <= '0;
            v1      <= 1'b0;
            clr1    <= 1'b0;
            lk1     <= 1'b0;
            we2     <= 1'b0;
            caddr1  <= '0;
            caddr2  <= '0;
            drain_q <= '0;
        end else begin
            if (accept) begin
                mode_q <= loop_mode_e'(mode_i);
                err_q  <= !legal;
                kt_n   <= K_size_i >> KSh;
                nt_n   <= N_size_i >> NSh;
                mt_max <= (M_size_i >> MSh) - SizeWidth'(1);
                kt_max <= (K_size_i >> KSh) - SizeWidth'(1);
                nt_max <= (N_size_i >> NSh) - SizeWidth'(1);
            end
            // Pipeline holds while stalled so no beat is lost or repeated.
            if (!stall_i) begin
                v1     <= issue;
                clr1   <= (kt == '0);
                lk1    <= kt_last;
                caddr1 <= c_full[AddrWidthC-1:0];
                we2    <= v1 && lk1;
                caddr2 <= caddr1;
            end
            if (state != DRAIN) begin
                drain_q <= '0;
            end else if (!stall_i) begin
                drain_q <= drain_q + 2'd1;
            end
        end
    end

`ifdef GEMM_SEQ_PERF_EN
    logic [31:0] cyc_q, stl_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || accept) begin
            cyc_q <= '0;
            stl_q <= '0;
        end else if (state == RUN || state == DRAIN) begin
            cyc_q <= cyc_q + 32'd1;
            if (stall_i) begin
                stl_q <= stl_q + 32'd1;
            end
        end
    end

    assign perf_cycles_o = cyc_q;
    assign perf_stalls_o = stl_q;
`endif

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Self-checking bench for gemm_tile_sequencer.
// Loop-nest reference model, random stalls and a scalar golden GEMM.
module tb_gemm_tile_sequencer;

    localparam int M   = 2;
    localparam int K   = 32;
    localparam int N   = 1;
    localparam int SW  = 7;
    localparam int AW  = 6;
    localparam int ACW = 9;

    logic           clk = 1'b0;
    logic           rst_i, start_i, mode_i, stall_i;
    logic [SW-1:0]  msz, ksz, nsz;
    logic [AW-1:0]  a_addr, b_addr;
    logic [ACW-1:0] c_addr;
    logic           mac_valid, acc_clear, c_we, busy, done, err;
`ifdef GEMM_SEQ_PERF_EN
    logic [31:0]    perf_cycles, perf_stalls;
`endif

    gemm_tile_sequencer #(
        .M(M), .K(K), .N(N),
        .SizeWidth(SW), .AddrWidth(AW), .AddrWidthC(ACW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .mode_i        (mode_i),
        .M_size_i      (msz),
        .K_size_i      (ksz),
        .N_size_i      (nsz),
        .stall_i       (stall_i),
        .sram_a_addr_o (a_addr),
        .sram_b_addr_o (b_addr),
        .mac_valid_o   (mac_valid),
        .acc_clear_o   (acc_clear),
        .sram_c_we_o   (c_we),
        .sram_c_addr_o (c_addr),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err)
`ifdef GEMM_SEQ_PERF_EN
        ,
        .perf_cycles_o (perf_cycles),
        .perf_stalls_o (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;
    int t0     = 0;
    bit rec    = 0;
    int st_lo0 = -1, st_hi0 = -1, st_lo1 = -1, st_hi1 = -1;

    int amem [64];
    int bmem [64];

    int ea[$], eb[$], eclr[$], ec[$], ecv[$];
    int oa[$], ob[$], oclr[$], oc[$], ocv[$];

    int pend_a, pend_b, acc, prev_a, prev_b;
    bit prev_stall;
    int n_done, done_at, n_err, err_at, last_we;
    int n_bad, n_unfrozen, n_stall, first_mv;

    // Observes the DUT mid-cycle; beats map to the last unstalled address.
    always @(negedge clk) begin
        if (!rec) begin
            oa.delete(); ob.delete(); oclr.delete();
            oc.delete(); ocv.delete();
            pend_a <= 0; pend_b <= 0; acc <= 0;
            prev_a <= 0; prev_b <= 0; prev_stall <= 0;
            n_done <= 0; done_at <= -1; n_err <= 0; err_at <= -1;
            last_we <= -1; n_bad <= 0; n_unfrozen <= 0;
            n_stall <= 0; first_mv <= -1;
        end else begin
            if (c_we) begin
                oc.push_back(int'(c_addr));
                ocv.push_back(acc);
                last_we <= cyc - t0;
            end
            if (mac_valid) begin
                oa.push_back(pend_a);
                ob.push_back(pend_b);
                oclr.push_back(int'(acc_clear));
                if (acc_clear) acc <= amem[pend_a] * bmem[pend_b];
                else acc <= acc + amem[pend_a] * bmem[pend_b];
                if (first_mv < 0) first_mv <= cyc - t0;
            end
            if (done) begin
                n_done <= n_done + 1;
                done_at <= cyc - t0;
            end
            if (err) begin
                n_err <= n_err + 1;
                err_at <= cyc - t0;
            end
            if (stall_i && (mac_valid || c_we)) n_bad <= n_bad + 1;
            if (stall_i && busy) n_stall <= n_stall + 1;
            if (stall_i && prev_stall
                && (int'(a_addr) != prev_a || int'(b_addr) != prev_b))
                n_unfrozen <= n_unfrozen + 1;
            if (!stall_i) begin
                pend_a <= int'(a_addr);
                pend_b <= int'(b_addr);
            end
            prev_stall <= stall_i;
            prev_a <= int'(a_addr);
            prev_b <= int'(b_addr);
        end
    end

    function automatic bit qne(int x[$], int y[$]);
        if (x.size() != y.size()) return 1'b1;
        foreach (x[i]) if (x[i] != y[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int seq_mask();
        int m = 0;
        if (qne(oa, ea)) m |= 1;
        if (qne(ob, eb)) m |= 2;
        if (qne(oclr, eclr)) m |= 4;
        if (qne(oc, ec)) m |= 8;
        if (qne(ocv, ecv)) m |= 16;
        return m;
    endfunction

    // Reference: plain loop nest over tiles in the requested order.
    task automatic build_model(input int ms, ks, ns, input bit md);
        int mtn, ktn, ntn, outer, inner, mt, nt, s;
        mtn = ms / M; ktn = ks / K; ntn = ns / N;
        ea.delete(); eb.delete(); eclr.delete();
        ec.delete(); ecv.delete();
        foreach (amem[i]) amem[i] = int'($urandom_range(0, 15));
        foreach (bmem[i]) bmem[i] = int'($urandom_range(0, 15));
        outer = md ? ntn : mtn;
        inner = md ? mtn : ntn;
        for (int o = 0; o < outer; o++) begin
            for (int i = 0; i < inner; i++) begin
                mt = md ? i : o;
                nt = md ? o : i;
                s = 0;
                for (int k = 0; k < ktn; k++) begin
                    ea.push_back((mt * ktn + k) % 64);
                    eb.push_back((k * ntn + nt) % 64);
                    eclr.push_back(k == 0 ? 1 : 0);
                    s += amem[(mt * ktn + k) % 64] * bmem[(k * ntn + nt) % 64];
                end
                ec.push_back((mt * ntn + nt) % 512);
                ecv.push_back(s);
            end
        end
    endtask

    task automatic begin_job(input int ms, ks, ns, input bit md);
        rec = 0;
        @(posedge clk); #1;
        rec = 1;
        @(posedge clk); #1;
        t0 = cyc;
        start_i = 1; mode_i = md;
        msz = SW'(ms); ksz = SW'(ks); nsz = SW'(ns);
    endtask

    // smode: 0 none, 1 fixed windows, 2 random while busy.
    task automatic run_job(input int ms, ks, ns, input bit md,
                           input int smode);
        int rel;
        begin_job(ms, ks, ns, md);
        stall_i = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            start_i = 0;
            rel = cyc - t0;
            case (smode)
                1: stall_i = (rel >= st_lo0 && rel <= st_hi0)
                          || (rel >= st_lo1 && rel <= st_hi1);
                2: stall_i = busy && ($urandom_range(0, 3) == 0);
                default: stall_i = 0;
            endcase
            if (n_done != 0 && rel > done_at + 3) break;
        end
        stall_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 1; start_i = 0; stall_i = 0; mode_i = 0;
        msz = '0; ksz = '0; nsz = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({a_addr, b_addr, c_addr} !== '0)
            $display("FAIL reset_addr: got %0h want 0",
                     {a_addr, b_addr, c_addr});
        else passed++;
        total++;
        if ({mac_valid, acc_clear, c_we, busy, done, err} !== 6'b0)
            $display("FAIL reset_strobes: got %b want 000000",
                     {mac_valid, acc_clear, c_we, busy, done, err});
        else passed++;
        rst_i = 0;
        @(posedge clk); #1;
        total++;
        if ({busy, done, mac_valid} !== 3'b0)
            $display("FAIL idle_after_reset: got %b want 000",
                     {busy, done, mac_valid});
        else passed++;
    endtask

    task automatic test_mode0();
        int m;
        build_model(4, 64, 16, 0);
        run_job(4, 64, 16, 0, 0);
        m = seq_mask();
        total++;
        if (m !== 0) $display("FAIL m0_seq: got mask %0d want 0", m);
        else passed++;
        total++;
        if (first_mv !== 2)
            $display("FAIL m0_first_valid: got %0d want 2", first_mv);
        else passed++;
        total++;
        if (last_we !== 66)
            $display("FAIL m0_last_we: got %0d want 66", last_we);
        else passed++;
        total++;
        if (done_at !== 67 || n_done !== 1)
            $display("FAIL m0_done: got %0d/%0d want 67/1", done_at, n_done);
        else passed++;
        total++;
        if (n_err !== 0 || busy !== 1'b0)
            $display("FAIL m0_err_busy: got %0d/%b want 0/0", n_err, busy);
        else passed++;
    endtask

    task automatic test_mode1();
        int m;
        build_model(4, 64, 16, 1);
        run_job(4, 64, 16, 1, 0);
        m = seq_mask();
        total++;
        if (m !== 0) $display("FAIL m1_seq: got mask %0d want 0", m);
        else passed++;
        total++;
        if (oc.size() < 4 || oc[1] !== 16 || oc[2] !== 1)
            $display("FAIL m1_c_order: got size %0d want 0,16,1 order",
                     oc.size());
        else passed++;
        total++;
        if (done_at !== 67)
            $display("FAIL m1_done: got %0d want 67", done_at);
        else passed++;
    endtask

    task automatic test_kt1();
        int m;
        build_model(32, 32, 32, 0);
        run_job(32, 32, 32, 0, 0);
        m = seq_mask();
        total++;
        if (m !== 0) $display("FAIL kt1_seq: got mask %0d want 0", m);
        else passed++;
        total++;
        if (oc.size() !== 512)
            $display("FAIL kt1_writes: got %0d want 512", oc.size());
        else passed++;
        total++;
        if (done_at !== 515)
            $display("FAIL kt1_done: got %0d want 515", done_at);
        else passed++;
    endtask

    task automatic test_stall();
        int m;
        st_lo0 = 10; st_hi0 = 14; st_lo1 = 70; st_hi1 = 72;
        build_model(4, 64, 16, 0);
        run_job(4, 64, 16, 0, 1);
        m = seq_mask();
        total++;
        if (m !== 0) $display("FAIL stall_seq: got mask %0d want 0", m);
        else passed++;
        total++;
        if (done_at !== 75)
            $display("FAIL stall_done: got %0d want 75", done_at);
        else passed++;
        total++;
        if (last_we !== 74)
            $display("FAIL stall_last_we: got %0d want 74", last_we);
        else passed++;
        total++;
        if (n_bad !== 0 || n_unfrozen !== 0)
            $display("FAIL stall_freeze: got %0d/%0d want 0/0",
                     n_bad, n_unfrozen);
        else passed++;
    endtask

    task automatic test_err();
        ea.delete(); ec.delete();
        run_job(4, 48, 16, 0, 0);
        total++;
        if (n_err !== 1 || err_at !== 1)
            $display("FAIL err_pulse: got %0d@%0d want 1@1", n_err, err_at);
        else passed++;
        total++;
        if (n_done !== 1 || done_at !== 1)
            $display("FAIL err_done: got %0d@%0d want 1@1", n_done, done_at);
        else passed++;
        total++;
        if (oa.size() !== 0 || oc.size() !== 0)
            $display("FAIL err_no_access: got %0d/%0d want 0/0",
                     oa.size(), oc.size());
        else passed++;
    endtask

    task automatic test_reset_mid();
        int m;
        begin_job(4, 64, 16, 0);
        stall_i = 0;
        repeat (20) begin
            @(posedge clk); #1;
            start_i = 0;
        end
        rst_i = 1;
        @(posedge clk); #1;
        rst_i = 0;
        total++;
        if ({a_addr, b_addr, c_addr, mac_valid, acc_clear,
             c_we, busy, done, err} !== '0)
            $display("FAIL rstmid_zero: got %0h want 0",
                     {a_addr, b_addr, c_addr, mac_valid, acc_clear,
                      c_we, busy, done, err});
        else passed++;
        repeat (80) @(posedge clk);
        #1;
        total++;
        if (n_done !== 0)
            $display("FAIL rstmid_no_done: got %0d want 0", n_done);
        else passed++;
        build_model(4, 64, 16, 0);
        run_job(4, 64, 16, 0, 0);
        m = seq_mask();
        total++;
        if (m !== 0 || done_at !== 67)
            $display("FAIL rstmid_restart: got %0d@%0d want 0@67",
                     m, done_at);
        else passed++;
    endtask

    task automatic test_random();
        int ms, ks, ns, m, want;
        bit md;
        for (int it = 0; it < 4; it++) begin
            ms = M * int'($urandom_range(1, 4));
            ks = K * int'($urandom_range(1, 3));
            ns = N * int'($urandom_range(1, 8));
            md = 1'($urandom_range(0, 1));
            build_model(ms, ks, ns, md);
            run_job(ms, ks, ns, md, 2);
            m = seq_mask();
            want = ea.size() + 3 + n_stall;
            total++;
            if (m !== 0)
                $display("FAIL rnd%0d_seq: got mask %0d want 0", it, m);
            else passed++;
            total++;
            if (done_at !== want)
                $display("FAIL rnd%0d_done: got %0d want %0d",
                         it, done_at, want);
            else passed++;
            total++;
            if (n_bad !== 0 || n_unfrozen !== 0)
                $display("FAIL rnd%0d_freeze: got %0d/%0d want 0/0",
                         it, n_bad, n_unfrozen);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_kt1();
        test_stall();
        test_err();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
